// File: rtl/rv32_pkg.sv
// Shared RV32I pipeline types and constants for the fetch/decode boundary.
package rv32_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0 -- a harmless instruction for decode to see when nothing is queued
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_pkt_t;

endpackage

// File: rtl/if_id_queue.sv
// Instruction buffer between fetch and decode. Show-ahead FIFO of {pc, instr} packets.
// Fetch stalls only when the queue is full (fetch.stall = ~in_ready).
// A redirect (flush = pc_sel) discards every buffered wrong-path packet in one cycle.
module if_id_queue
    import rv32_pkg::*;
#(
    parameter int               DEPTH     = 4,
    parameter logic [XLEN-1:0]  NOP_INSTR = rv32_pkg::NOP_INSTR
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [XLEN-1:0]           in_pc,
    input  logic [XLEN-1:0]           in_instr,
    output logic                      in_ready,
    input  logic                      flush,
    output logic                      out_valid,
    output logic [XLEN-1:0]           out_pc,
    output logic [XLEN-1:0]           out_instr,
    input  logic                      out_ready,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Pointers wrap naturally at PW bits because DEPTH is a power of two;
    // the extra count bit is what separates full from empty.
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    fetch_pkt_t    mem_q [DEPTH];

    logic push;
    logic pop;

    // Handshake qualifiers; in_ready depends on state only, never on out_ready.
    always_comb begin
        in_ready  = (count_q != CW'(DEPTH));
        out_valid = (count_q != '0);
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;
    end

    // Next-state for pointers and occupancy; flush wins over push and pop.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Pointer and count registers; reset empties the queue immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Packet storage; contents are left unreset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= '{pc: in_pc, instr: in_instr};
        end
    end

    // Show-ahead head outputs, forced to a NOP packet at pc 0 when empty.
    always_comb begin
        out_pc    = '0;
        out_instr = NOP_INSTR;
        if (out_valid) begin
            out_pc    = mem_q[rd_ptr_q].pc;
            out_instr = mem_q[rd_ptr_q].instr;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue (DEPTH=4).
module tb_if_id_queue;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready;
    logic [2:0]  count;

    int passed;
    int total;

    if_id_queue #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .out_ready (out_ready),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'hDEAD_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Advance one clock; sample and drive 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = instr_of(pc);
        out_ready = rdy;
        flush     = fl;
    endtask

    task automatic head_is(input string tag, input logic [31:0] pc);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_pc"}, out_pc, pc);
        chk({tag, "_instr"}, out_instr, instr_of(pc));
    endtask

    task automatic empty_is(input string tag);
        chk({tag, "_count"}, {29'd0, count}, 32'd0);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_instr"}, out_instr, 32'h0000_0013);
        chk({tag, "_pc"}, out_pc, 32'd0);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst    = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #12;
        empty_is("reset");
        rst = 1'b1;
        step();

        // 1. asynchronous reset mid-stream with three packets queued
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h100 + 32'(4 * i), 1'b0, 1'b0);
            step();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("pre_rst_count", {29'd0, count}, 32'd3);
        head_is("pre_rst_head", 32'h100);
        #2 rst = 1'b0;
        #1;
        empty_is("async_rst");
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        step();
        empty_is("post_rst");

        // 2. fill to DEPTH with decode stalled, then an ignored fifth push
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(4 * i), 1'b0, 1'b0);
            step();
        end
        chk("fill_count", {29'd0, count}, 32'd4);
        chk("fill_in_ready", {31'd0, in_ready}, 32'd0);
        head_is("fill_head", 32'h0);
        drive(1'b1, 32'h10, 1'b0, 1'b0);
        step();
        chk("full_ignore_count", {29'd0, count}, 32'd4);
        head_is("full_ignore_head", 32'h0);

        // 3. drain in order
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            head_is("drain", 32'(4 * i));
            step();
        end
        empty_is("drained");

        // 4. steady streaming at occupancy 1, pointers wrap several times
        drive(1'b1, 32'h200, 1'b0, 1'b0);
        chk("no_bypass_valid", {31'd0, out_valid}, 32'd0);
        step();
        chk("stream_start_count", {29'd0, count}, 32'd1);
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 32'h204 + 32'(4 * k), 1'b1, 1'b0);
            head_is("stream", 32'h200 + 32'(4 * k));
            step();
            chk("stream_count", {29'd0, count}, 32'd1);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        head_is("stream_last", 32'h250);
        step();
        empty_is("stream_end");

        // 5. flush drops queued packets and the same-cycle push
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h300 + 32'(4 * i), 1'b0, 1'b0);
            step();
        end
        chk("preflush_count", {29'd0, count}, 32'd3);
        drive(1'b1, 32'h40, 1'b1, 1'b1);
        step();
        empty_is("flush");
        drive(1'b1, 32'h80, 1'b0, 1'b0);
        step();
        head_is("post_flush", 32'h80);
        chk("post_flush_count", {29'd0, count}, 32'd1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        step();
        empty_is("post_flush_pop");

        // 6. full, pop frees a slot, refill, then verify order
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h500 + 32'(4 * i), 1'b0, 1'b0);
            step();
        end
        chk("full2_count", {29'd0, count}, 32'd4);
        chk("full2_in_ready", {31'd0, in_ready}, 32'd0);
        // push attempt while full alongside a pop: only the pop happens
        drive(1'b1, 32'h5F0, 1'b1, 1'b0);
        step();
        chk("full_pop_count", {29'd0, count}, 32'd3);
        chk("full_pop_in_ready", {31'd0, in_ready}, 32'd1);
        head_is("full_pop_head", 32'h504);
        drive(1'b1, 32'h510, 1'b0, 1'b0);
        step();
        chk("refill_count", {29'd0, count}, 32'd4);
        chk("refill_in_ready", {31'd0, in_ready}, 32'd0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            head_is("refill_drain", 32'h504 + 32'(4 * i));
            step();
        end
        empty_is("refill_drained");

        // push+pop while empty: only the push takes effect
        drive(1'b1, 32'h600, 1'b1, 1'b0);
        step();
        chk("empty_pushpop_count", {29'd0, count}, 32'd1);
        head_is("empty_pushpop_head", 32'h600);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        step();
        empty_is("final");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
